// File: rtl/dict_table_sched.sv
// Single-port dictionary table scheduler: optional preload from memory, then one read grant per cycle.
// Define DICT_SCHED_PRELOAD_EN to enable the LOAD phase; otherwise the table is filled externally.
module dict_table_sched #(
  parameter int unsigned IDX_SIZE     = 8,
  parameter int unsigned VAL_SIZE     = 15,
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [31:0]         mem_req_addr,
  input  logic [31:0]         mem_req_rdata,
  output logic                tbl_en,
  output logic                tbl_we,
  output logic [IDX_SIZE-1:0] tbl_addr,
  output logic [VAL_SIZE-1:0] tbl_wdata,
  input  logic [VAL_SIZE-1:0] tbl_rdata,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [IDX_SIZE-1:0] dec_key,
  output logic                dec_rsp_valid,
  output logic [VAL_SIZE-1:0] dec_rsp_val,
  input  logic                fill_valid,
  output logic                fill_ready,
  input  logic [IDX_SIZE-1:0] fill_key,
  output logic                fill_rsp_valid,
  output logic [VAL_SIZE-1:0] fill_rsp_val,
  output logic                load_done
);
  localparam int unsigned       WAIT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  typedef enum logic {LOAD, SERVE} state_t;

`ifdef DICT_SCHED_PRELOAD_EN
  localparam state_t RST_STATE = LOAD;
  logic [IDX_SIZE:0] idx, idx_nxt;
  logic              unused_in;
  assign unused_in = ^mem_req_rdata[31:VAL_SIZE];
`else
  localparam state_t RST_STATE = SERVE;
  logic              unused_in;
  assign unused_in = ^{BASE_ADDR, mem_req_ready, mem_req_rdata};
`endif

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              grant_dec, grant_fill;
  logic              rsp_pend, rsp_tag;

  // load_done doubles as the "serving" qualifier so the no-preload build stays idle until the first edge.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    tbl_en        = 1'b0;
    tbl_we        = 1'b0;
    tbl_addr      = '0;
    tbl_wdata     = '0;
    grant_dec     = 1'b0;
    grant_fill    = 1'b0;
    state_nxt     = state;
`ifdef DICT_SCHED_PRELOAD_EN
    idx_nxt       = idx;
`endif
    if (!reset) begin
      if (load_done) begin
        grant_fill = fill_valid && (!dec_valid || wait_cnt == WAIT_MAX);
        grant_dec  = dec_valid && !grant_fill;
        tbl_en     = grant_fill || grant_dec;
        if (grant_fill)     tbl_addr = fill_key;
        else if (grant_dec) tbl_addr = dec_key;
      end
`ifdef DICT_SCHED_PRELOAD_EN
      else if (state == LOAD) begin
        mem_req_valid = 1'b1;
        mem_req_addr  = BASE_ADDR + (32'(idx) << 2);
        if (mem_req_ready) begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = idx[IDX_SIZE-1:0];
          tbl_wdata = mem_req_rdata[VAL_SIZE-1:0];
          idx_nxt   = idx + 1'b1;
          if (idx[IDX_SIZE-1:0] == '1) state_nxt = SERVE;
        end
      end
`endif
    end
  end

  assign dec_ready      = grant_dec;
  assign fill_ready     = grant_fill;
  assign dec_rsp_valid  = rsp_pend && !rsp_tag;
  assign fill_rsp_valid = rsp_pend && rsp_tag;
  assign dec_rsp_val    = dec_rsp_valid  ? tbl_rdata : '0;
  assign fill_rsp_val   = fill_rsp_valid ? tbl_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RST_STATE;
      wait_cnt  <= '0;
      rsp_pend  <= 1'b0;
      rsp_tag   <= 1'b0;
      load_done <= 1'b0;
`ifdef DICT_SCHED_PRELOAD_EN
      idx       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      load_done <= (state_nxt == SERVE);
      rsp_pend  <= grant_dec || grant_fill;
      rsp_tag   <= grant_fill;
`ifdef DICT_SCHED_PRELOAD_EN
      idx       <= idx_nxt;
`endif
      if (!fill_valid || grant_fill)  wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dict_table_sched.sv
// Bench for dict_table_sched: preload (when DICT_SCHED_PRELOAD_EN is defined), vector table, random vs model, resets.
module tb_dict_table_sched;
  localparam int unsigned IDX  = 3;
  localparam int unsigned VAL  = 15;
  localparam int unsigned N    = 8;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int unsigned LIM  = 4;

  logic           clk;
  logic           reset;
  logic           mem_req_valid, mem_req_ready;
  logic [31:0]    mem_req_addr, mem_req_rdata;
  logic           tbl_en, tbl_we;
  logic [IDX-1:0] tbl_addr;
  logic [VAL-1:0] tbl_wdata, tbl_rdata;
  logic           dec_valid, dec_ready, dec_rsp_valid;
  logic [IDX-1:0] dec_key;
  logic [VAL-1:0] dec_rsp_val;
  logic           fill_valid, fill_ready, fill_rsp_valid;
  logic [IDX-1:0] fill_key;
  logic [VAL-1:0] fill_rsp_val;
  logic           load_done;

  logic           mem_ready;
  logic [VAL-1:0] sram [N];
  logic [VAL-1:0] tmodel [N];
  logic           bk_we;
  logic [IDX-1:0] bk_addr;
  logic [VAL-1:0] bk_data;

  int n_chk = 0;
  int n_fail = 0;

  dict_table_sched #(
    .IDX_SIZE(IDX), .VAL_SIZE(VAL), .BASE_ADDR(BASE), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rdata(mem_req_rdata),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_key(dec_key),
    .dec_rsp_valid(dec_rsp_valid), .dec_rsp_val(dec_rsp_val),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_key(fill_key),
    .fill_rsp_valid(fill_rsp_valid), .fill_rsp_val(fill_rsp_val),
    .load_done(load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word i at BASE + 4*i holds 0xA0 + i; junk when not ready.
  assign mem_req_ready = mem_ready;
  assign mem_req_rdata = mem_ready ? 32'hA0 + ((mem_req_addr - BASE) >> 2) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (bk_we) sram[bk_addr] <= bk_data;
    else if (tbl_en && tbl_we) sram[tbl_addr] <= tbl_wdata;
    if (tbl_en && !tbl_we) tbl_rdata <= sram[tbl_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic backdoor_fill();
    for (int i = 0; i < N; i++) begin
      bk_we = 1'b1; bk_addr = IDX'(i); bk_data = tmodel[i];
      tick();
    end
    bk_we = 1'b0;
  endtask

`ifdef DICT_SCHED_PRELOAD_EN
  task automatic run_preload(input int stop_after, input int stall_idx);
    int e = 0;
    int stalls = 0;
    for (int c = 0; c < 64 && e < stop_after; c++) begin
      mem_ready = !(e == stall_idx && stalls < 3);
      #4;
      check("pre load_done", load_done, 0);
      check("pre mem_req_valid", mem_req_valid, 1);
      check("pre mem_req_addr", mem_req_addr, BASE + 4 * e);
      check("pre tbl_en", tbl_en, mem_ready);
      check("pre tbl_we", tbl_we, mem_ready);
      check("pre dec_ready", dec_ready, 0);
      if (mem_ready) begin
        check("pre tbl_addr", tbl_addr, e);
        check("pre tbl_wdata", tbl_wdata, 32'hA0 + e);
        e++;
      end else begin
        check("pre stall tbl_wdata", tbl_wdata, 0);
        stalls++;
      end
      tick();
    end
    mem_ready = 1'b0;
    if (e < stop_after) check("pre timeout", e, stop_after);
  endtask
`endif

  typedef struct {
    logic dv; logic [IDX-1:0] dk; logic fv; logic [IDX-1:0] fk;
    logic dr; logic fr; logic drv; logic frv; logic [VAL-1:0] rval;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic dv, input int dk, input logic fv, input int fk,
                     input logic dr, input logic fr, input logic drv, input logic frv, input int rval);
    vecs.push_back('{dv, IDX'(dk), fv, IDX'(fk), dr, fr, drv, frv, VAL'(rval)});
  endtask

  initial begin
    int  starve;
    bit  pv, pf, dw, fw, dw_prev, fw_prev;
    logic [VAL-1:0] pval;

    for (int i = 0; i < N; i++) tmodel[i] = VAL'(32'hA0 + i);
    tmodel[5] = 15'h1234;

    reset = 1'b1; mem_ready = 1'b1; bk_we = 1'b0; bk_addr = '0; bk_data = '0;
    dec_valid = 1'b1; dec_key = '0; fill_valid = 1'b1; fill_key = '0;
    #1;
    backdoor_fill();
    #4;
    check("rst load_done", load_done, 0);
    check("rst mem_req_valid", mem_req_valid, 0);
    check("rst mem_req_addr", mem_req_addr, 0);
    check("rst tbl_en", tbl_en, 0);
    check("rst tbl_we", tbl_we, 0);
    check("rst tbl_wdata", tbl_wdata, 0);
    check("rst dec_ready", dec_ready, 0);
    check("rst fill_ready", fill_ready, 0);
    check("rst dec_rsp_valid", dec_rsp_valid, 0);
    check("rst fill_rsp_valid", fill_rsp_valid, 0);
    tick();
    reset = 1'b0; fill_valid = 1'b0; mem_ready = 1'b0;

`ifdef DICT_SCHED_PRELOAD_EN
    // Partial preload, reset at idx=4, then a full preload with a 3-cycle stall at idx=2.
    run_preload(4, 99);
    reset = 1'b1;
    #4;
    check("midload rst load_done", load_done, 0);
    check("midload rst mem_req_valid", mem_req_valid, 0);
    check("midload rst tbl_en", tbl_en, 0);
    tick();
    reset = 1'b0;
    run_preload(8, 2);
    for (int i = 0; i < N; i++) tmodel[i] = VAL'(32'hA0 + i);
`else
    #4;
    check("post-rst load_done", load_done, 0);
    check("post-rst dec_ready", dec_ready, 0);
    tick();
`endif
    // First serve cycle: grant possible immediately.
    #4;
    check("serve load_done", load_done, 1);
    check("serve mem_req_valid", mem_req_valid, 0);
    check("serve mem_req_addr", mem_req_addr, 0);
    check("serve tbl_we", tbl_we, 0);
    check("first dec_ready", dec_ready, 1);
    check("first tbl_en", tbl_en, 1);
    check("first tbl_addr", tbl_addr, 0);
    tick();
    dec_valid = 1'b0;
    #4;
    check("first dec_rsp_valid", dec_rsp_valid, 1);
    check("first dec_rsp_val", dec_rsp_val, tmodel[0]);
    check("first fill_rsp_valid", fill_rsp_valid, 0);
    tick();

    tmodel[5] = 15'h1234;
    backdoor_fill();

    //  dv dk fv fk  dr fr drv frv rval
    add(1, 5, 0, 0,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1, 0, 'h1234);
    add(1, 1, 0, 0,  1, 0, 0, 0, 0);
    add(0, 0, 1, 2,  0, 1, 1, 0, 'hA1);
    add(1, 1, 0, 0,  1, 0, 0, 1, 'hA2);
    add(0, 0, 1, 2,  0, 1, 1, 0, 'hA1);
    add(0, 0, 0, 0,  0, 0, 0, 1, 'hA2);
    add(1, 3, 1, 6,  1, 0, 0, 0, 0);
    for (int r = 0; r < 3; r++) add(1, 3, 1, 6, 1, 0, 1, 0, 'hA3);
    add(1, 3, 1, 6,  0, 1, 1, 0, 'hA3);
    add(1, 3, 1, 6,  1, 0, 0, 1, 'hA6);
    for (int r = 0; r < 3; r++) add(1, 3, 1, 6, 1, 0, 1, 0, 'hA3);
    add(1, 3, 1, 6,  0, 1, 1, 0, 'hA3);
    add(0, 0, 0, 0,  0, 0, 0, 1, 'hA6);
    add(1, 3, 1, 6,  1, 0, 0, 0, 0);
    add(1, 3, 1, 6,  1, 0, 1, 0, 'hA3);
    add(1, 3, 0, 0,  1, 0, 1, 0, 'hA3);
    for (int r = 0; r < 4; r++) add(1, 3, 1, 6, 1, 0, 1, 0, 'hA3);
    add(1, 3, 1, 6,  0, 1, 1, 0, 'hA3);
    add(0, 0, 0, 0,  0, 0, 0, 1, 'hA6);

    foreach (vecs[i]) begin
      dec_valid = vecs[i].dv; dec_key = vecs[i].dk;
      fill_valid = vecs[i].fv; fill_key = vecs[i].fk;
      #4;
      check($sformatf("vec%0d dec_ready", i), dec_ready, vecs[i].dr);
      check($sformatf("vec%0d fill_ready", i), fill_ready, vecs[i].fr);
      check($sformatf("vec%0d tbl_en", i), tbl_en, vecs[i].dr | vecs[i].fr);
      if (vecs[i].fr)      check($sformatf("vec%0d tbl_addr", i), tbl_addr, vecs[i].fk);
      else if (vecs[i].dr) check($sformatf("vec%0d tbl_addr", i), tbl_addr, vecs[i].dk);
      check($sformatf("vec%0d dec_rsp_valid", i), dec_rsp_valid, vecs[i].drv);
      check($sformatf("vec%0d fill_rsp_valid", i), fill_rsp_valid, vecs[i].frv);
      if (vecs[i].drv) check($sformatf("vec%0d dec_rsp_val", i), dec_rsp_val, vecs[i].rval);
      if (vecs[i].frv) check($sformatf("vec%0d fill_rsp_val", i), fill_rsp_val, vecs[i].rval);
      tick();
    end

    // Random traffic; ungranted requests hold valid and key.
    starve = 0; pv = 0; pf = 0; pval = '0; dw_prev = 1; fw_prev = 1;
    dec_valid = 1'b0; fill_valid = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!dec_valid || dw_prev) begin
        dec_valid = ($urandom_range(0, 9) < 6);
        dec_key = IDX'($urandom_range(0, N - 1));
      end
      if (!fill_valid || fw_prev) begin
        fill_valid = ($urandom_range(0, 9) < 5);
        fill_key = IDX'($urandom_range(0, N - 1));
      end
      #4;
      fw = fill_valid && (!dec_valid || starve >= LIM);
      dw = dec_valid && !fw;
      check("rnd dec_ready", dec_ready, dw);
      check("rnd fill_ready", fill_ready, fw);
      check("rnd tbl_en", tbl_en, dw | fw);
      check("rnd tbl_we", tbl_we, 0);
      if (fw)      check("rnd tbl_addr", tbl_addr, fill_key);
      else if (dw) check("rnd tbl_addr", tbl_addr, dec_key);
      check("rnd dec_rsp_valid", dec_rsp_valid, pv && !pf);
      check("rnd fill_rsp_valid", fill_rsp_valid, pv && pf);
      if (pv && !pf) check("rnd dec_rsp_val", dec_rsp_val, pval);
      if (pv && pf)  check("rnd fill_rsp_val", fill_rsp_val, pval);
      pv = dw || fw; pf = fw;
      pval = fw ? tmodel[fill_key] : tmodel[dec_key];
      if (fw || !fill_valid) starve = 0;
      else if (starve < LIM) starve++;
      dw_prev = dw; fw_prev = fw;
      tick();
    end
    dec_valid = 1'b0; fill_valid = 1'b0;
    tick();

    // Reset with a response in flight: it must be dropped.
    dec_valid = 1'b1; dec_key = 3'd3;
    #4;
    check("inflight dec_ready", dec_ready, 1);
    tick();
    reset = 1'b1; dec_valid = 1'b0;
    #4;
    check("inflight rst dec_rsp_valid", dec_rsp_valid, 0);
    check("inflight rst load_done", load_done, 0);
    check("inflight rst tbl_en", tbl_en, 0);
    tick();
    reset = 1'b0;
    #4;
    check("after rst dec_rsp_valid", dec_rsp_valid, 0);
    check("after rst fill_rsp_valid", fill_rsp_valid, 0);
    check("after rst load_done", load_done, 0);
`ifdef DICT_SCHED_PRELOAD_EN
    check("after rst mem_req_valid", mem_req_valid, 1);
    check("after rst mem_req_addr", mem_req_addr, BASE);
`else
    tick();
    #4;
    check("after rst edge load_done", load_done, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
